// File: rtl/font_overlay_if.sv
// ============================================================================
// Module   : font_overlay_if
// Purpose  : Timing, text-write and font ROM signals of the font overlay path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface font_overlay_if;
   logic        en;
   logic        blink;
   logic        de;
   logic        hs;
   logic        vs;
   logic        txt_we;
   logic [3:0]  txt_addr;
   logic [3:0]  txt_data;
   logic [10:0] rom_addr;
   logic        rom_q;
   logic        overlay_en;
   logic        de_o;
   logic        hs_o;
   logic        vs_o;
   logic        frame_done;

   modport master (
      output en, blink, de, hs, vs, txt_we, txt_addr, txt_data, rom_q,
      input  rom_addr, overlay_en, de_o, hs_o, vs_o, frame_done
   );

   modport slave (
      input  en, blink, de, hs, vs, txt_we, txt_addr, txt_data, rom_q,
      output rom_addr, overlay_en, de_o, hs_o, vs_o, frame_done
   );
endinterface

`default_nettype wire

// File: rtl/font_overlay_ctrl.sv
// ============================================================================
// Module   : font_overlay_ctrl
// Purpose  : Font ROM overlay sequencer with double-buffered 16-glyph text line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module font_overlay_ctrl #(
   parameter int WIN_X0    = 400,
   parameter int WIN_Y0    = 500,
   parameter int NUM_CHARS = 16,
   parameter int CHAR_W    = 8,
   parameter int CHAR_H    = 16,
   parameter int BLINK_SH  = 5
) (
   input  wire logic       clk,
   input  wire logic       rst,
   font_overlay_if.slave   bus
);

   localparam logic [11:0] c_X0  = 12'(WIN_X0);
   localparam logic [11:0] c_X1  = 12'(WIN_X0 + NUM_CHARS * CHAR_W);
   localparam logic [11:0] c_Y0  = 12'(WIN_Y0);
   localparam logic [11:0] c_Y1  = 12'(WIN_Y0 + CHAR_H);
   localparam logic [11:0] c_MAX = 12'hFFF;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_WIN = 2'd1,
      S_IN_WIN   = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_de_q;
   logic        r_vs_q;
   logic [11:0] r_x;
   logic [11:0] r_y;
   logic [7:0]  r_fcnt;
   logic        r_blink_l;
   logic [3:0]  r_shadow [16];
   logic [3:0]  r_active [16];

   logic [10:0] r_addr;
   logic        r_hit1;
   logic        r_hit2;
   logic        r_fdone;
   logic        r_de1, r_hs1, r_vs1;
   logic        r_de2, r_hs2, r_vs2;

   logic        w_frame_start;
   logic        w_de_fall;
   logic        w_hit;
   logic        w_enter;
   logic        w_last;
   logic        w_issue;
   logic [6:0]  w_dx;
   logic [3:0]  w_dy;

   assign w_frame_start = bus.vs & ~r_vs_q;
   assign w_de_fall     = ~bus.de & r_de_q;
   assign w_dx          = 7'(r_x - c_X0);
   assign w_dy          = 4'(r_y - c_Y0);
   assign w_hit         = bus.de & (r_x >= c_X0) & (r_x < c_X1) & (r_y >= c_Y0) & (r_y < c_Y1);
   assign w_enter       = bus.de & (r_y == c_Y0);
   assign w_last        = (w_dx == 7'h7F) & (w_dy == 4'hF);

   // Frame start overrides everything: a half-drawn window is simply abandoned.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      if (w_frame_start) begin
         w_state_nxt = bus.en ? S_WAIT_WIN : S_IDLE;
      end else begin
         case (r_state)
            S_WAIT_WIN: begin
               if (w_enter) begin
                  w_state_nxt = S_IN_WIN;
                  w_issue     = w_hit;
               end
            end
            S_IN_WIN: w_issue = w_hit;
            default:  w_issue = 1'b0;
         endcase
         if (w_issue && w_last) begin
            w_state_nxt = S_DONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_de_q    <= 1'b0;
         r_vs_q    <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_fcnt    <= '0;
         r_blink_l <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         r_de_q <= bus.de;
         r_vs_q <= bus.vs;
         if (!bus.de) begin
            r_x <= '0;
         end else if (r_x != c_MAX) begin
            r_x <= r_x + 12'd1;
         end
         if (w_frame_start) begin
            r_y <= '0;
         end else if (w_de_fall && (r_y != c_MAX)) begin
            r_y <= r_y + 12'd1;
         end
         // Active copy samples the shadow before any same-cycle write lands.
         if (w_frame_start) begin
            r_fcnt    <= r_fcnt + 8'd1;
            r_blink_l <= bus.blink;
            for (int i = 0; i < 16; i++) begin
               r_active[i] <= r_shadow[i];
            end
         end
         if (bus.txt_we) begin
            r_shadow[bus.txt_addr] <= bus.txt_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_hit1  <= 1'b0;
         r_hit2  <= 1'b0;
         r_fdone <= 1'b0;
         r_de1   <= 1'b0;
         r_hs1   <= 1'b0;
         r_vs1   <= 1'b0;
         r_de2   <= 1'b0;
         r_hs2   <= 1'b0;
         r_vs2   <= 1'b0;
      end else begin
         if (w_issue) begin
            r_addr <= {r_active[w_dx[6:3]], w_dy, w_dx[2:0]};
         end
         r_hit1  <= w_issue;
         r_hit2  <= r_hit1;
         r_fdone <= w_issue & w_last;
         r_de1   <= bus.de;
         r_hs1   <= bus.hs;
         r_vs1   <= bus.vs;
         r_de2   <= r_de1;
         r_hs2   <= r_hs1;
         r_vs2   <= r_vs1;
      end
   end

   assign bus.rom_addr   = r_addr;
   assign bus.frame_done = r_fdone;
   assign bus.de_o       = r_de2;
   assign bus.hs_o       = r_hs2;
   assign bus.vs_o       = r_vs2;
   assign bus.overlay_en = r_hit2 & r_de2 & bus.rom_q & ~(r_blink_l & r_fcnt[BLINK_SH]);

endmodule

`default_nettype wire

// File: tb/tb_font_overlay_ctrl.sv
// ============================================================================
// Module   : tb_font_overlay_ctrl
// Purpose  : Scoreboard bench for font_overlay_ctrl on a reduced-size raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_font_overlay_ctrl;

   localparam int X0 = 20;
   localparam int Y0 = 3;
   localparam int SH = 0;

   logic clk = 1'b1;
   logic rst;
   always #5 clk = ~clk;

   font_overlay_if bus ();

   font_overlay_ctrl #(
      .WIN_X0(X0), .WIN_Y0(Y0), .NUM_CHARS(16), .CHAR_W(8), .CHAR_H(16), .BLINK_SH(SH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic font [2048];
   always @(posedge clk) bus.rom_q <= font[bus.rom_addr];

   typedef struct packed {
      logic        rst;
      logic        de;
      logic        hs;
      logic        vs;
      logic        hit;
      logic        ov;
      logic        fd;
      logic [10:0] addr;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   logic [3:0] m_shadow [16];
   logic [3:0] m_active [16];
   logic [7:0] m_fcnt;
   logic       m_armed, m_blink, m_done;
   logic       g_wr_ok;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      m_fcnt = '0; m_armed = 1'b0; m_blink = 1'b0; m_done = 1'b0;
   endtask

   // One pixel clock: apply timing, predict the response, queue it.
   task automatic step(input logic fs, input logic d, input logic h, input logic v,
                       input int col, input int line);
      exp_t e;
      e = '0;
      bus.de = d; bus.hs = h; bus.vs = v;
      if (rst) begin
         model_reset();
         e.rst = 1'b1;
      end else begin
         if (fs) begin
            m_fcnt++;
            for (int i = 0; i < 16; i++) m_active[i] = m_shadow[i];
            m_armed = bus.en; m_blink = bus.blink; m_done = 1'b0;
         end
         e.de = d; e.hs = h; e.vs = v;
         if (!fs && d && m_armed && !m_done && col >= X0 && col < X0 + 128 &&
             line >= Y0 && line < Y0 + 16) begin
            int s, c, r;
            s = (col - X0) / 8; c = (col - X0) % 8; r = line - Y0;
            e.hit  = 1'b1;
            e.addr = {m_active[s], 4'(r), 3'(c)};
            e.ov   = font[e.addr] & ~(m_blink & m_fcnt[SH]);
            if (s == 15 && c == 7 && r == 15) begin
               e.fd = 1'b1; m_done = 1'b1;
            end
         end
         if (bus.txt_we) m_shadow[bus.txt_addr] = bus.txt_data;
      end
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic rand_side();
      bus.en       = 1'($urandom_range(0, 1));
      bus.blink    = 1'($urandom_range(0, 1));
      bus.txt_we   = g_wr_ok && ($urandom_range(0, 15) == 0);
      bus.txt_addr = 4'($urandom);
      bus.txt_data = 4'($urandom);
   endtask

   task automatic frame(input int en_fs, input int blink_fs, input int we_fs,
                        input int w, input int nl, input int rst_line);
      rand_side();
      bus.en = 1'(en_fs); bus.blink = 1'(blink_fs);
      if (we_fs != 0) begin
         bus.txt_we = 1'b1; bus.txt_addr = 4'd0; bus.txt_data = 4'($urandom_range(6, 15));
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
      repeat (3) begin rand_side(); step(1'b0, 1'b0, 1'b0, 1'b1, -1, -1); end
      repeat (4) begin rand_side(); step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1); end
      for (int ln = 0; ln < nl; ln++) begin
         repeat (3) begin rand_side(); step(1'b0, 1'b0, 1'b1, 1'b0, -1, ln); end
         repeat (2) begin rand_side(); step(1'b0, 1'b0, 1'b0, 1'b0, -1, ln); end
         for (int cx = 0; cx < w; cx++) begin
            if (ln == rst_line && cx == 40) rst = 1'b1;
            if (ln == rst_line && cx == 43) rst = 1'b0;
            rand_side();
            step(1'b0, 1'b1, 1'b0, 1'b0, cx, ln);
         end
         repeat (2) begin rand_side(); step(1'b0, 1'b0, 1'b0, 1'b0, -1, ln); end
      end
   endtask

   task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   exp_t d1 = '0;
   exp_t d2 = '0;

   always @(negedge clk) begin
      exp_t cur;
      if (q.size() > 0) begin
         cur = q.pop_front();
         if (cur.rst) begin
            chk("reset_outputs", {6'd0, bus.de_o, bus.hs_o, bus.vs_o, bus.overlay_en, bus.frame_done}, 11'd0);
            chk("reset_rom_addr", bus.rom_addr, 11'd0);
         end else begin
            chk("syncs", {8'd0, bus.de_o, bus.hs_o, bus.vs_o}, {8'd0, d2.de, d2.hs, d2.vs});
            chk("overlay_en", {10'd0, bus.overlay_en}, {10'd0, d2.ov});
            chk("frame_done", {10'd0, bus.frame_done}, {10'd0, d1.fd});
            if (d1.hit) chk("rom_addr", bus.rom_addr, d1.addr);
         end
         d2 = d1;
         d1 = cur;
      end
   end

   initial begin
      for (int i = 0; i < 2048; i++) font[i] = 1'($urandom_range(0, 1));
      font[11'h280] = 1'b1;
      font[11'h1FF] = 1'b1;
      model_reset();
      g_wr_ok = 1'b0;
      rst = 1'b1;
      bus.en = 1'b0; bus.blink = 1'b0; bus.txt_we = 1'b0;
      bus.txt_addr = '0; bus.txt_data = '0;
      bus.de = 1'b0; bus.hs = 1'b0; bus.vs = 1'b0;
      repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
      bus.txt_we = 1'b1; bus.txt_addr = 4'd0;  bus.txt_data = 4'd5;
      step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
      bus.txt_we = 1'b1; bus.txt_addr = 4'd15; bus.txt_data = 4'd3;
      step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
      bus.txt_we = 1'b0;

      frame(1, 0, 0, 160, 21, -1);
      frame(1, 0, 0, 160, 21, -1);      // glyph 5 at slot 0, glyph 3 at slot 15
      frame(1, 0, 1, 160, 21, -1);      // write at frame start: old glyph still shown
      g_wr_ok = 1'b1;
      frame(0, 0, 0, 160, 21, -1);      // en rises only mid-frame
      frame(1, 0, 0, 160, 21, -1);
      frame(1, 1, 0, 160, 21, -1);      // even frame count: blink visible
      frame(1, 1, 0, 160, 21, -1);      // odd frame count: blink suppressed
      frame(1, 0, 0, 160, 21, Y0 + 5);  // reset inside the window
      frame(1, 0, 0, 160, 21, -1);
      for (int f = 0; f < 3; f++) begin
         frame(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)), int'($urandom_range(130, 160)),
               int'($urandom_range(17, 21)), -1);
      end
      repeat (4) begin rand_side(); step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1); end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
